// File: rtl/gate_deadtime.sv
// gate_deadtime: complementary gate generation with programmable dead time
// for two half-bridges (primary and secondary, two legs each).
//
// Ports:
//   clk     system clock, all logic on the rising edge
//   rst     synchronous active-high reset
//   en      converter enable; low forces every gate off and clears err
//   cmd_p   primary leg commands, bit k = 1 requests leg k high side on
//   cmd_s   secondary leg commands, same encoding
//   dt_cfg  dead time in cycles, captured only while en = 0 (0 loads as 1)
//   gp      primary gates, gp[2k] = leg k high side, gp[2k+1] = leg k low side
//   gs      secondary gates, same mapping
//   err     sticky flag: a command changed while its leg was in dead time
module gate_deadtime #(
  parameter int unsigned DT_W   = 8,
  parameter int unsigned DT_DEF = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [1:0]      cmd_p,
  input  logic [1:0]      cmd_s,
  input  logic [DT_W-1:0] dt_cfg,
  output logic [3:0]      gp,
  output logic [3:0]      gs,
  output logic            err
);

  localparam int unsigned NLEG = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  // Legs 0/1 are the primary bridge, legs 2/3 the secondary bridge.
  logic [NLEG-1:0] cmd;
  assign cmd = {cmd_s, cmd_p};

  logic [DT_W-1:0] dt_r;
  logic [DT_W-1:0] dt_m1;
  assign dt_m1 = dt_r - DT_W'(1);

  state_t          state_q [NLEG];
  state_t          state_d [NLEG];
  logic [DT_W-1:0] cnt_q   [NLEG];
  logic [DT_W-1:0] cnt_d   [NLEG];
  logic [NLEG-1:0] tgt_q;
  logic [NLEG-1:0] tgt_d;
  logic [NLEG-1:0] retrig;
  logic [2*NLEG-1:0] gate_q;
  logic [2*NLEG-1:0] gate_d;

  // Dead-time register; only reloaded while the converter is disabled so a
  // running leg never sees its dead time change mid-flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      dt_r <= DT_W'(DT_DEF);
    end else if (!en) begin
      dt_r <= (dt_cfg == '0) ? DT_W'(1) : dt_cfg;
    end
  end

  // State register for all four legs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NLEG; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      tgt_q <= '0;
    end else begin
      for (int i = 0; i < NLEG; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      tgt_q <= tgt_d;
    end
  end

  // Next-state logic. The counter is loaded with dt_r-1 on entry to DEAD so
  // that the opposite gate rises exactly dt_r edges after the command edge.
  always_comb begin
    for (int i = 0; i < NLEG; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
    end
    tgt_d  = tgt_q;
    retrig = '0;

    for (int i = 0; i < NLEG; i++) begin
      if (!en) begin
        state_d[i] = ST_IDLE;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            state_d[i] = ST_DEAD;
            tgt_d[i]   = cmd[i];
            cnt_d[i]   = dt_m1;
          end
          ST_DEAD: begin
            if (cmd[i] != tgt_q[i]) begin
              // Pulse shorter than the dead time: restart and flag it.
              tgt_d[i]  = cmd[i];
              cnt_d[i]  = dt_m1;
              retrig[i] = 1'b1;
            end else if (cnt_q[i] == '0) begin
              state_d[i] = tgt_q[i] ? ST_HIGH : ST_LOW;
            end else begin
              cnt_d[i] = cnt_q[i] - DT_W'(1);
            end
          end
          ST_HIGH: begin
            if (!cmd[i]) begin
              state_d[i] = ST_DEAD;
              tgt_d[i]   = 1'b0;
              cnt_d[i]   = dt_m1;
            end
          end
          ST_LOW: begin
            if (cmd[i]) begin
              state_d[i] = ST_DEAD;
              tgt_d[i]   = 1'b1;
              cnt_d[i]   = dt_m1;
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
          end
        endcase
      end
    end
  end

  // Output decode from the next state, so the gate registers change on the
  // same edge as the state and turn-off takes effect on the command edge.
  always_comb begin
    gate_d = '0;
    for (int i = 0; i < NLEG; i++) begin
      gate_d[2*i]   = (state_d[i] == ST_HIGH);
      gate_d[2*i+1] = (state_d[i] == ST_LOW);
    end
  end

  // Registered gate outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_q <= '0;
    end else begin
      gate_q <= gate_d;
    end
  end

  // Sticky short-pulse flag, cleared whenever the converter is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (!en) begin
      err <= 1'b0;
    end else if (|retrig) begin
      err <= 1'b1;
    end
  end

  assign gp = gate_q[3:0];
  assign gs = gate_q[7:4];

endmodule

// File: tb/tb_gate_deadtime.sv
// Self-checking bench for gate_deadtime: directed scenarios followed by
// randomized command traffic, all compared against a cycle-level model that
// tracks, per leg, how long the target has been stable.
module tb_gate_deadtime;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] cmd_p;
  logic [1:0] cmd_s;
  logic [7:0] dt_cfg;
  logic [3:0] gp;
  logic [3:0] gs;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit m_run  [4];
  bit m_cond [4];
  bit m_tgt  [4];
  int m_age  [4];
  int m_dt;
  bit m_err;

  gate_deadtime #(.DT_W(8), .DT_DEF(10)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .cmd_p  (cmd_p),
    .cmd_s  (cmd_s),
    .dt_cfg (dt_cfg),
    .gp     (gp),
    .gs     (gs),
    .err    (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the model: a leg conducts once its target has been
  // stable for dt cycles since it was last set; any change restarts that.
  task automatic model_edge();
    logic [3:0] c;
    c = {cmd_s, cmd_p};
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_run[i] = 0; m_cond[i] = 0; m_tgt[i] = 0; m_age[i] = 0;
      end
      m_dt  = 10;
      m_err = 0;
    end else if (!en) begin
      for (int i = 0; i < 4; i++) begin
        m_run[i] = 0; m_cond[i] = 0;
      end
      m_err = 0;
      m_dt  = (dt_cfg == 0) ? 1 : int'(dt_cfg);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!m_run[i]) begin
          m_run[i] = 1; m_tgt[i] = c[i]; m_age[i] = 0; m_cond[i] = 0;
        end else if (m_cond[i]) begin
          if (c[i] != m_tgt[i]) begin
            m_tgt[i] = c[i]; m_age[i] = 0; m_cond[i] = 0;
          end
        end else if (c[i] != m_tgt[i]) begin
          m_tgt[i] = c[i]; m_age[i] = 0; m_err = 1;
        end else begin
          m_age[i]++;
          if (m_age[i] >= m_dt) m_cond[i] = 1;
        end
      end
    end
  endtask

  // Advance one edge, update the model, then compare just after the edge.
  task automatic cycle();
    logic [7:0] exp_g;
    logic [7:0] g;
    @(posedge clk);
    model_edge();
    #1;
    exp_g = '0;
    for (int i = 0; i < 4; i++) begin
      exp_g[2*i]   = m_cond[i] & m_tgt[i];
      exp_g[2*i+1] = m_cond[i] & ~m_tgt[i];
    end
    g = {gs, gp};
    check_eq("gp", 32'(gp), 32'(exp_g[3:0]));
    check_eq("gs", 32'(gs), 32'(exp_g[7:4]));
    check_eq("err", 32'(err), 32'(m_err));
    check_eq("no_overlap", 32'(g & (g >> 1) & 8'h55), 32'h0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; cmd_p = 2'b11; cmd_s = 2'b00; dt_cfg = 8'd10;

    // Reset held with en=1 and commands active.
    repeat (3) begin
      cycle();
      check_eq("rst_gp", 32'(gp), 32'h0);
      check_eq("rst_gs", 32'(gs), 32'h0);
      check_eq("rst_err", 32'(err), 32'h0);
    end
    rst = 1'b0;
    cycle();
    for (int k = 1; k <= 10; k++) begin
      cycle();
      check_eq("rst_release_gp", 32'(gp), (k == 10) ? 32'h5 : 32'h0);
    end
    check_eq("rst_release_gs", 32'(gs), 32'ha);

    // Leg 0 high -> low: immediate turn-off, 10 dead cycles, low side on.
    cmd_p = 2'b10;
    cycle();
    check_eq("turnoff", 32'(gp[1:0]), 32'h0);
    for (int k = 1; k <= 10; k++) begin
      cycle();
      check_eq("dead10", 32'(gp[1:0]), (k == 10) ? 32'h2 : 32'h0);
    end

    // Short pulse in dead time: restart counter, set err.
    cmd_p = 2'b11;
    cycle();
    repeat (4) cycle();
    cmd_p = 2'b10;
    repeat (3) cycle();
    check_eq("glitch_err", 32'(err), 32'h1);
    cmd_p = 2'b11;
    cycle();
    for (int k = 1; k <= 10; k++) begin
      cycle();
      check_eq("glitch_restart", 32'(gp[1:0]), (k == 10) ? 32'h1 : 32'h0);
    end
    check_eq("glitch_sticky", 32'(err), 32'h1);

    // Enable drop while conducting.
    en = 1'b0;
    cycle();
    check_eq("endrop_gp", 32'(gp), 32'h0);
    check_eq("endrop_gs", 32'(gs), 32'h0);
    check_eq("endrop_err", 32'(err), 32'h0);
    en = 1'b1;
    cycle();
    for (int k = 1; k <= 10; k++) begin
      cycle();
      check_eq("reen_gp", 32'(gp), (k == 10) ? 32'h5 : 32'h0);
    end

    // dt_cfg=0 gives a one-cycle dead time; changes while enabled ignored.
    dt_cfg = 8'd0;
    en = 1'b0;
    cycle();
    en = 1'b1;
    cycle();
    cycle();
    check_eq("dt1_on", 32'(gp), 32'h5);
    dt_cfg = 8'd20;
    cmd_p = 2'b00;
    cycle();
    check_eq("dt1_off", 32'(gp), 32'h0);
    cycle();
    check_eq("dt1_keep", 32'(gp), 32'ha);

    // All four legs switching on the same edge with dt=3.
    dt_cfg = 8'd3;
    en = 1'b0;
    cycle();
    en = 1'b1;
    cmd_p = 2'b00; cmd_s = 2'b00;
    cycle();
    repeat (3) cycle();
    check_eq("all_low_gp", 32'(gp), 32'ha);
    check_eq("all_low_gs", 32'(gs), 32'ha);
    cmd_p = 2'b11; cmd_s = 2'b11;
    cycle();
    check_eq("all_off", 32'({gs, gp}), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      cycle();
      check_eq("all_gp", 32'(gp), (k == 3) ? 32'h5 : 32'h0);
      check_eq("all_gs", 32'(gs), (k == 3) ? 32'h5 : 32'h0);
    end

    // Randomized traffic: commands, enable drops, config changes, resets.
    for (int ph = 0; ph < 8; ph++) begin
      dt_cfg = 8'($urandom_range(0, 12));
      en = 1'b0;
      repeat (2) cycle();
      en = 1'b1;
      for (int n = 0; n < 300; n++) begin
        if ($urandom_range(0, 15) == 0) begin
          int b;
          b = int'($urandom_range(0, 3));
          if (b < 2) cmd_p[b] = ~cmd_p[b];
          else       cmd_s[b-2] = ~cmd_s[b-2];
        end
        if ($urandom_range(0, 39) == 0) dt_cfg = 8'($urandom_range(0, 12));
        en  = ($urandom_range(0, 199) != 0);
        rst = ($urandom_range(0, 299) == 0);
        cycle();
      end
      rst = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
